ring_phase_decoder: RTL and testbench
=====================================

// Module: ring_phase_decoder
// PURPOSE
//  Receive-side decoder for the 4-bit active-low one-hot ring-counter phase bus.
//  Converts the ring code into a 2-bit phase index and checks that successive codes follow the legal rotation.
//  Locks after a run of correct steps, counts revolutions, and flags sequence errors.
//  Sits beside the ring counter and feeds phase info and health status to the datapath control and debug logic.
// PARAMETERS
//  LOCK_COUNT  4  consecutive correct transitions needed to enter LOCKED (legal range 1..15)
//  REV_W       8  width of the revolution counter
// PORTS
//  clock       in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-high
//  ring_in     in   4      ring code sample, active-low one-hot
//  in_valid    in   1      ring_in is a new sample; the ring has advanced exactly one step since the last valid sample
//  clear_err   in   1      synchronous clear of err_sticky
//  phase       out  2      decoded phase of the last legal sample
//  phase_valid out  1      the last valid sample was a legal code
//  locked      out  1      FSM is in LOCKED
//  seq_err     out  1      one-cycle pulse: sequence error detected while LOCKED
//  err_sticky  out  1      set by seq_err; held until clear_err or reset
//  wrap        out  1      one-cycle pulse: phase 3->0 step accepted while LOCKED
//  rev_count   out  REV_W  count of wraps, modulo 2^REV_W
// BEHAVIOUR
//  Legal codes (phase): 1110=0, 0111=1, 1011=2, 1101=3. Legal rotation is p -> (p+1) mod 4.
//  Every other code is illegal, including 1111, 0000 and any code with two or more zero bits.
//  Outputs and state update on the clock edge that samples in_valid=1.
//  All outputs are registered: 1-cycle latency from the sample edge.
//  When in_valid=0, all state is held and seq_err and wrap are driven 0.
//  Reset value: FSM=HUNT, last=0, run=0. Outputs: phase=0, phase_valid=0, locked=0, seq_err=0, err_sticky=0, wrap=0, rev_count=0.
//  "ok" means the sample is legal AND its phase equals last+1 (mod 4). Each legal sample updates last and phase.
//  A repeated (stalled) code is not ok.
//  FSM, evaluated on each valid sample:
//   HUNT:    legal -> LOCKING, run=0.  Illegal -> stay in HUNT, phase_valid=0.
//   LOCKING: ok -> run++; if run+1==LOCK_COUNT -> LOCKED.
//            Legal but not ok -> stay in LOCKING, run=0.
//            Illegal -> HUNT.  No seq_err is raised in LOCKING.
//   LOCKED:  ok -> stay in LOCKED; if the step is 3->0, pulse wrap and increment rev_count.
//            Legal but not ok -> pulse seq_err, go to LOCKING, run=0.
//            Illegal -> pulse seq_err, go to HUNT.
//  rev_count wraps from all-ones to 0. It is not cleared by clear_err, and is cleared only by reset.
//  err_sticky: a set (seq_err) in the same cycle as clear_err wins, so the flag stays 1.
//  The step that completes the lock, including a 3->0 step, does not pulse wrap.
//  Reset asserted mid-operation forces the reset values immediately (asynchronously).
//  After reset, locking restarts from HUNT.
// TESTING
//  1 Reset, then 1110,0111,1011,1101,1110 with in_valid=1 each cycle (LOCK_COUNT=4)
//    -> locked=1 after the 5th sample; phase=0,1,2,3,0; wrap=0 throughout.
//  2 From state 1, continue the rotation for 3 more revolutions
//    -> wrap pulses on each 1101->1110 step; rev_count=3.
//  3 While LOCKED, inject 1011 where 0111 is expected
//    -> seq_err pulses one cycle; err_sticky=1; locked=0; 4 further correct steps relock.
//  4 While LOCKED, inject 1111
//    -> seq_err pulse, phase_valid=0, FSM in HUNT; the next legal code starts LOCKING.
//  5 Assert clear_err in the same cycle as a new seq_err -> err_sticky stays 1.
//    Assert clear_err alone later -> err_sticky=0.
//  6 in_valid=0 gaps between samples -> no state change; a stalled repeated code while LOCKED -> seq_err.
//    Assert reset mid-revolution -> all outputs return to 0.

Source files
------------

// File: rtl/ring_phase_if.sv
// Bundle between the ring-phase decoder and its user: the sample stream in,
// the decoded phase and health status out.
//
// Handshake: there is no ready. in_valid=1 on a rising clock edge means ring_in
// holds a fresh sample that is exactly one ring step after the previous valid
// sample; the decoder always accepts it. in_valid=0 means "no sample": nothing
// advances. clear_err is independent of in_valid.
interface ring_phase_if #(
  parameter int REV_W = 8
) ();
  logic [3:0]       ring_in;
  logic             in_valid;
  logic             clear_err;
  logic [1:0]       phase;
  logic             phase_valid;
  logic             locked;
  logic             seq_err;
  logic             err_sticky;
  logic             wrap;
  logic [REV_W-1:0] rev_count;
  logic [1:0]       dbg_state;   // FSM state: 0=HUNT, 1=LOCKING, 2=LOCKED

  modport master (
    output ring_in, in_valid, clear_err,
    input  phase, phase_valid, locked, seq_err, err_sticky, wrap, rev_count, dbg_state
  );

  modport slave (
    input  ring_in, in_valid, clear_err,
    output phase, phase_valid, locked, seq_err, err_sticky, wrap, rev_count, dbg_state
  );
endinterface

// File: rtl/ring_phase_decoder.sv
// Receive-side decoder for the 4-bit active-low one-hot ring phase bus.
// Decodes each sample to a phase index, checks it follows the p -> p+1 rotation,
// locks after LOCK_COUNT correct steps, counts revolutions and flags sequence errors.
// All outputs are registered and change on the edge that samples in_valid=1.
module ring_phase_decoder #(
  parameter int LOCK_COUNT = 4,   // 1..15
  parameter int REV_W      = 8
) (
  input logic        clock,
  input logic        reset,
  ring_phase_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

  state_t           r_state;
  logic [1:0]       r_last;
  logic [3:0]       r_run;
  logic [1:0]       r_phase;
  logic             r_phase_valid;
  logic             r_seq_err;
  logic             r_err_sticky;
  logic             r_wrap;
  logic [REV_W-1:0] r_rev_count;

  state_t           w_state_nxt;
  logic [1:0]       w_last_nxt;
  logic [3:0]       w_run_nxt;
  logic [1:0]       w_phase_nxt;
  logic             w_phase_valid_nxt;
  logic             w_seq_err_nxt;
  logic             w_err_sticky_nxt;
  logic             w_wrap_nxt;
  logic [REV_W-1:0] w_rev_count_nxt;

  logic             w_legal;
  logic [1:0]       w_code_phase;
  logic [1:0]       w_last_inc;
  logic             w_ok;

  // Decode the ring code; anything other than the four single-zero codes is illegal.
  always_comb begin
    w_legal      = 1'b0;
    w_code_phase = 2'd0;
    case (bus.ring_in)
      4'b1110: begin w_legal = 1'b1; w_code_phase = 2'd0; end
      4'b0111: begin w_legal = 1'b1; w_code_phase = 2'd1; end
      4'b1011: begin w_legal = 1'b1; w_code_phase = 2'd2; end
      4'b1101: begin w_legal = 1'b1; w_code_phase = 2'd3; end
      default: begin w_legal = 1'b0; w_code_phase = 2'd0; end
    endcase
  end

  // A step is correct only if it lands on last+1 mod 4; a stalled code is not.
  assign w_last_inc = r_last + 2'd1;
  assign w_ok       = w_legal && (w_code_phase == w_last_inc);

  // Next-state and next-output logic, evaluated only on valid samples.
  always_comb begin
    w_state_nxt       = r_state;
    w_last_nxt        = r_last;
    w_run_nxt         = r_run;
    w_phase_nxt       = r_phase;
    w_phase_valid_nxt = r_phase_valid;
    w_seq_err_nxt     = 1'b0;
    w_wrap_nxt        = 1'b0;
    w_rev_count_nxt   = r_rev_count;

    if (bus.in_valid) begin
      case (r_state)
        HUNT: begin
          if (w_legal) begin
            w_state_nxt = LOCKING;
            w_run_nxt   = 4'd0;
          end
        end
        LOCKING: begin
          if (w_ok) begin
            if (r_run + 4'd1 == LOCK_RUN) begin
              // The locking step never reports a wrap, even when it is 3->0.
              w_state_nxt = LOCKED;
              w_run_nxt   = 4'd0;
            end else begin
              w_run_nxt   = r_run + 4'd1;
            end
          end else if (w_legal) begin
            w_run_nxt   = 4'd0;
          end else begin
            w_state_nxt = HUNT;
            w_run_nxt   = 4'd0;
          end
        end
        LOCKED: begin
          if (w_ok) begin
            if (r_last == 2'd3) begin
              w_wrap_nxt      = 1'b1;
              w_rev_count_nxt = r_rev_count + REV_W'(1);
            end
          end else if (w_legal) begin
            w_seq_err_nxt = 1'b1;
            w_state_nxt   = LOCKING;
            w_run_nxt     = 4'd0;
          end else begin
            w_seq_err_nxt = 1'b1;
            w_state_nxt   = HUNT;
            w_run_nxt     = 4'd0;
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_run_nxt   = 4'd0;
        end
      endcase

      if (w_legal) begin
        w_last_nxt        = w_code_phase;
        w_phase_nxt       = w_code_phase;
        w_phase_valid_nxt = 1'b1;
      end else begin
        w_phase_valid_nxt = 1'b0;
      end
    end

    // A new error outranks a clear arriving in the same cycle.
    if (w_seq_err_nxt) begin
      w_err_sticky_nxt = 1'b1;
    end else if (bus.clear_err) begin
      w_err_sticky_nxt = 1'b0;
    end else begin
      w_err_sticky_nxt = r_err_sticky;
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= HUNT;
      r_last        <= 2'd0;
      r_run         <= 4'd0;
      r_phase       <= 2'd0;
      r_phase_valid <= 1'b0;
      r_seq_err     <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_wrap        <= 1'b0;
      r_rev_count   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last        <= w_last_nxt;
      r_run         <= w_run_nxt;
      r_phase       <= w_phase_nxt;
      r_phase_valid <= w_phase_valid_nxt;
      r_seq_err     <= w_seq_err_nxt;
      r_err_sticky  <= w_err_sticky_nxt;
      r_wrap        <= w_wrap_nxt;
      r_rev_count   <= w_rev_count_nxt;
    end
  end

  assign bus.phase       = r_phase;
  assign bus.phase_valid = r_phase_valid;
  assign bus.locked      = (r_state == LOCKED);
  assign bus.seq_err     = r_seq_err;
  assign bus.err_sticky  = r_err_sticky;
  assign bus.wrap        = r_wrap;
  assign bus.rev_count   = r_rev_count;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Bench for ring_phase_decoder: directed scenarios followed by random sample
// streams, every cycle compared against a behavioural model of the phase rules.
module tb_ring_phase_decoder;

  localparam int LOCK_COUNT = 4;
  localparam int REV_W      = 8;
  localparam int W          = 17;  // packed expected-output width

  logic clock;
  logic reset;

  ring_phase_if #(.REV_W(REV_W)) bus ();

  ring_phase_decoder #(.LOCK_COUNT(LOCK_COUNT), .REV_W(REV_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  logic [3:0] codes [4];
  initial begin
    codes[0] = 4'b1110;
    codes[1] = 4'b0111;
    codes[2] = 4'b1011;
    codes[3] = 4'b1101;
  end

  // Reference model: mode 0=hunting, 1=locking, 2=locked.
  int m_mode, m_last, m_run, m_phase, m_pv, m_seq, m_sticky, m_wrap, m_rev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_run = 0; m_phase = 0; m_pv = 0;
    m_seq = 0; m_sticky = 0; m_wrap = 0; m_rev = 0;
  endtask

  // Look the code up in the table of legal codes.
  task automatic classify(input logic [3:0] code, output int legal, output int p);
    legal = 0;
    p = 0;
    for (int k = 0; k < 4; k++) begin
      if (codes[k] == code) begin
        legal = 1;
        p = k;
      end
    end
  endtask

  task automatic model_step(input logic [3:0] code, input logic v, input logic clr);
    int legal, p, ok;
    m_seq  = 0;
    m_wrap = 0;
    if (v) begin
      classify(code, legal, p);
      ok = legal && (p == (m_last + 1) % 4);
      if (m_mode == 0) begin
        if (legal) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        if (ok) begin
          m_run = m_run + 1;
          if (m_run == LOCK_COUNT) begin m_mode = 2; m_run = 0; end
        end else if (legal) m_run = 0;
        else begin m_mode = 0; m_run = 0; end
      end else begin
        if (ok) begin
          if (m_last == 3) begin
            m_wrap = 1;
            m_rev  = (m_rev + 1) % (1 << REV_W);
          end
        end else begin
          m_seq  = 1;
          m_mode = legal ? 1 : 0;
          m_run  = 0;
        end
      end
      if (legal) begin m_last = p; m_phase = p; m_pv = 1; end
      else m_pv = 0;
    end
    if (m_seq) m_sticky = 1;
    else if (clr) m_sticky = 0;
    exp_q.push_back({2'(m_phase), 1'(m_pv), 1'(m_mode == 2), 1'(m_seq), 1'(m_sticky),
                     1'(m_wrap), REV_W'(m_rev), 2'(m_mode)});
  endtask

  task automatic compare(input string where);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({where, ".queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({where, ".phase"},       32'(bus.phase),       32'(e[16:15]));
    chk({where, ".phase_valid"}, 32'(bus.phase_valid), 32'(e[14]));
    chk({where, ".locked"},      32'(bus.locked),      32'(e[13]));
    chk({where, ".seq_err"},     32'(bus.seq_err),     32'(e[12]));
    chk({where, ".err_sticky"},  32'(bus.err_sticky),  32'(e[11]));
    chk({where, ".wrap"},        32'(bus.wrap),        32'(e[10]));
    chk({where, ".rev_count"},   32'(bus.rev_count),   32'(e[9:2]));
    chk({where, ".state"},       32'(bus.dbg_state),   32'(e[1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string where, input logic [3:0] code, input logic v, input logic clr);
    @(negedge clock);
    bus.ring_in   = code;
    bus.in_valid  = v;
    bus.clear_err = clr;
    @(posedge clock);
    model_step(code, v, clr);
    #1;
    compare(where);
  endtask

  task automatic step_ph(input string where, input int p);
    step(where, codes[p % 4], 1'b1, 1'b0);
  endtask

  task automatic step_next(input string where);
    step_ph(where, m_last + 1);
  endtask

  task automatic check_all_zero(input string where);
    chk({where, ".phase"},       32'(bus.phase),       32'd0);
    chk({where, ".phase_valid"}, 32'(bus.phase_valid), 32'd0);
    chk({where, ".locked"},      32'(bus.locked),      32'd0);
    chk({where, ".seq_err"},     32'(bus.seq_err),     32'd0);
    chk({where, ".err_sticky"},  32'(bus.err_sticky),  32'd0);
    chk({where, ".wrap"},        32'(bus.wrap),        32'd0);
    chk({where, ".rev_count"},   32'(bus.rev_count),   32'd0);
    chk({where, ".state"},       32'(bus.dbg_state),   32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int wraps;
    bus.ring_in   = 4'b1111;
    bus.in_valid  = 1'b0;
    bus.clear_err = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // 1: first lock, the locking 3->0 step must not wrap
    for (int i = 0; i < 5; i++) step_ph("t1", i);
    chk("t1.locked_after_5", 32'(bus.locked), 32'd1);
    chk("t1.no_wrap_on_lock", 32'(bus.wrap), 32'd0);
    chk("t1.phase0", 32'(bus.phase), 32'd0);

    // 2: three revolutions while locked
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      step_next("t2");
      if (bus.wrap === 1'b1) wraps++;
    end
    chk("t2.wrap_pulses", 32'(wraps), 32'd3);
    chk("t2.rev_count", 32'(bus.rev_count), 32'd3);

    // 3: skip a phase while locked, then relock
    step("t3.skip", codes[2], 1'b1, 1'b0);
    chk("t3.seq_err", 32'(bus.seq_err), 32'd1);
    chk("t3.unlocked", 32'(bus.locked), 32'd0);
    step_next("t3.after");
    chk("t3.seq_err_one_cycle", 32'(bus.seq_err), 32'd0);
    chk("t3.sticky_held", 32'(bus.err_sticky), 32'd1);
    for (int i = 0; i < 3; i++) step_next("t3.relock");
    chk("t3.relocked", 32'(bus.locked), 32'd1);

    // 4: illegal all-ones code while locked
    step("t4.ones", 4'b1111, 1'b1, 1'b0);
    chk("t4.seq_err", 32'(bus.seq_err), 32'd1);
    chk("t4.phase_valid", 32'(bus.phase_valid), 32'd0);
    chk("t4.hunt", 32'(bus.dbg_state), 32'd0);
    step_ph("t4.legal", 3);
    chk("t4.locking", 32'(bus.dbg_state), 32'd1);
    for (int i = 0; i < 4; i++) step_next("t4.relock");

    // 5: clear colliding with a new error, then a clear on its own
    step("t5.stall_clr", codes[m_last], 1'b1, 1'b1);
    chk("t5.set_wins", 32'(bus.err_sticky), 32'd1);
    step("t5.clr", 4'b0000, 1'b0, 1'b1);
    chk("t5.cleared", 32'(bus.err_sticky), 32'd0);

    // 6: gaps hold state, stall while locked errs, async reset mid-revolution
    for (int i = 0; i < 4; i++) step_next("t6.relock");
    for (int i = 0; i < 3; i++) step("t6.gap", 4'(i + 5), 1'b0, 1'b0);
    chk("t6.gap_locked", 32'(bus.locked), 32'd1);
    step_next("t6.after_gap");
    step("t6.stall", codes[m_last], 1'b1, 1'b0);
    chk("t6.stall_seq", 32'(bus.seq_err), 32'd1);
    for (int i = 0; i < 6; i++) step_next("t6.run");
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_all_zero("t6.async_reset");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step_ph("t6.post_reset", 1);
    chk("t6.restart_locking", 32'(bus.dbg_state), 32'd1);

    // random streams
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      step("rnd", codes[(m_last + 1) % 4], 1'b1, 1'($urandom_range(0, 9) == 0));
      else if (r < 78) step("rnd", codes[m_last], 1'b1, 1'($urandom_range(0, 9) == 0));
      else if (r < 84) step("rnd", codes[(m_last + 2) % 4], 1'b1, 1'b0);
      else if (r < 90) step("rnd", 4'($urandom_range(0, 15)), 1'b1, 1'b0);
      else             step("rnd", 4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
